// File: rtl/add8u_arb4_if.sv
// rtl/add8u_arb4_if.sv - request/response bundle for the shared approximate adder
interface add8u_arb4_if #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [8*NREQ-1:0] req_a;
    logic [8*NREQ-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [8:0]        rsp_sum;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum
    );
endinterface

// File: rtl/add8u_arb4.sv
// rtl/add8u_arb4.sv - round-robin scheduler in front of one approximate add8u
// Optional error monitor enabled by defining ADD8U_ARB_STATS_EN.
module add8u_arb4 #(
    parameter int NREQ  = 4,
    parameter int IDW   = $clog2(NREQ),
    parameter int ACC_W = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    add8u_arb4_if.slave      bus,
    input  logic             stat_clr,
    output logic [15:0]      stat_ops,
    output logic [3:0]       stat_err_max,
    output logic [ACC_W-1:0] stat_err_acc
);
    typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

    state_t         state_q;
    logic [IDW-1:0] ptr_q, lat_id_q, rsp_id_q;
    logic [7:0]     lat_a_q, lat_b_q;
    logic [8:0]     rsp_sum_q;
    logic           rsp_valid_q;

    logic [IDW-1:0] scan_idx, grant_idx, ptr_d;
    logic           grant_found, accept_win, xfer;
    logic [7:0]     grant_a, grant_b;
    logic [8:0]     approx_sum;

    // Scan from the highest offset down so the nearest valid index to ptr wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            scan_idx = IDW'((int'(ptr_q) + k) % NREQ);
            if (bus.req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    // rst_n gates the accept window so no grant is offered while held in reset.
    assign accept_win    = rst_n && ((state_q == IDLE) || ((state_q == HOLD) && bus.rsp_ready));
    assign xfer          = accept_win && grant_found;
    assign bus.req_ready = xfer ? (NREQ'(1) << grant_idx) : '0;
    assign grant_a       = bus.req_a[{grant_idx, 3'b000} +: 8];
    assign grant_b       = bus.req_b[{grant_idx, 3'b000} +: 8];
    assign ptr_d         = IDW'((int'(grant_idx) + 1) % NREQ);

    assign approx_sum[8:4] = {1'b0, lat_a_q[7:4]} + {1'b0, lat_b_q[7:4]}
                           + {4'b0000, lat_a_q[3] & lat_b_q[3]};
    assign approx_sum[3:0] = {1'b1, lat_b_q[2], lat_a_q[5], lat_a_q[7] ^ lat_b_q[7]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            lat_id_q    <= '0;
            lat_a_q     <= '0;
            lat_b_q     <= '0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            if (xfer) begin
                lat_a_q  <= grant_a;
                lat_b_q  <= grant_b;
                lat_id_q <= grant_idx;
                ptr_q    <= ptr_d;
            end
            case (state_q)
                IDLE: if (xfer) state_q <= CALC;
                CALC: begin
                    rsp_sum_q   <= approx_sum;
                    rsp_id_q    <= lat_id_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= HOLD;
                end
                HOLD: if (bus.rsp_ready) begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= xfer ? CALC : IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_sum   = rsp_sum_q;

`ifdef ADD8U_ARB_STATS_EN
    logic [8:0]     exact_sum, rsp_exact_q, err_raw;
    logic [3:0]     err_abs;
    logic           rsp_hs, unused_err_hi;
    logic [15:0]    ops_q;
    logic [3:0]     err_max_q;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W:0]   acc_sum;

    assign exact_sum = {1'b0, lat_a_q} + {1'b0, lat_b_q};
    assign err_raw   = (rsp_exact_q >= rsp_sum_q) ? (rsp_exact_q - rsp_sum_q)
                                                  : (rsp_sum_q - rsp_exact_q);
    // The approximation error never exceeds 11, so four bits carry it fully.
    assign err_abs       = err_raw[3:0];
    assign unused_err_hi = |err_raw[8:4];
    assign rsp_hs        = rsp_valid_q && bus.rsp_ready;
    assign acc_sum       = {1'b0, acc_q} + (ACC_W+1)'(err_abs);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_exact_q <= '0;
            ops_q       <= '0;
            err_max_q   <= '0;
            acc_q       <= '0;
        end else begin
            if (state_q == CALC) rsp_exact_q <= exact_sum;
            if (stat_clr) begin
                ops_q     <= '0;
                err_max_q <= '0;
                acc_q     <= '0;
            end else if (rsp_hs) begin
                ops_q     <= (ops_q == 16'hFFFF) ? ops_q : ops_q + 16'd1;
                err_max_q <= (err_abs > err_max_q) ? err_abs : err_max_q;
                acc_q     <= acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
            end
        end
    end

    assign stat_ops     = ops_q;
    assign stat_err_max = err_max_q;
    assign stat_err_acc = acc_q;
`else
    logic unused_stat_clr;
    assign unused_stat_clr = stat_clr;
    assign stat_ops        = '0;
    assign stat_err_max    = '0;
    assign stat_err_acc    = '0;
`endif
endmodule

// File: tb/tb_add8u_arb4.sv
// tb/tb_add8u_arb4.sv - scoreboard bench for add8u_arb4 (honours ADD8U_ARB_STATS_EN)
`timescale 1ns/1ps
module tb_add8u_arb4;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
`ifdef ADD8U_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stat_clr = 1'b0;
    logic [15:0] stat_ops;
    logic [3:0]  stat_err_max;
    logic [19:0] stat_err_acc;

    add8u_arb4_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    add8u_arb4 #(.NREQ(NREQ), .IDW(IDW), .ACC_W(20)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .stat_clr     (stat_clr),
        .stat_ops     (stat_ops),
        .stat_err_max (stat_err_max),
        .stat_err_acc (stat_err_acc)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [8:0] sum;
        int         xcyc;
    } rsp_t;

    rsp_t       sb[$];
    int         grant_q[$];
    int         acc_cycles[$];
    logic [8:0] cur_exp [NREQ];
    int         n_total = 0;
    int         n_pass = 0;
    int         cyc = 0;
    int         accepts = 0;
    bit         presented = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    // Accept watcher: grant order, one-hot grant, and scoreboard push.
    always @(negedge clk) begin
        if (rst_n && (bus.req_ready != '0)) begin
            int g;
            g = 0;
            for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) g = i;
            chk("grant_onehot", $countones(bus.req_ready), 1);
            chk("grant_has_valid", int'(bus.req_valid[g]), 1);
            if (grant_q.size() > 0) begin
                chk("grant_id", g, grant_q[0]);
                void'(grant_q.pop_front());
            end else begin
                chk("unexpected_grant", g, -1);
            end
            sb.push_back('{g, cur_exp[g], cyc});
            acc_cycles.push_back(cyc);
            accepts++;
        end
    end

    // Response monitor: latency on first presentation, contents on handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            presented = 1'b0;
        end else if (bus.rsp_valid) begin
            if (sb.size() == 0) begin
                if (!presented) chk("stale_rsp", 1, 0);
                presented = !bus.rsp_ready;
            end else begin
                if (!presented) begin
                    chk("latency", cyc - sb[0].xcyc, 2);
                    presented = 1'b1;
                end
                if (bus.rsp_ready) begin
                    chk("rsp_id", int'(bus.rsp_id), sb[0].id);
                    chk("rsp_sum", int'(bus.rsp_sum), int'(sb[0].sum));
                    void'(sb.pop_front());
                    presented = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic [8:0] e);
        bus.req_a[8*i +: 8] = a;
        bus.req_b[8*i +: 8] = b;
        cur_exp[i] = e;
    endtask

    task automatic wait_accepts(input int target, input string name);
        int n;
        n = 0;
        while (accepts < target && n < 50) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk(name, accepts, target);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((sb.size() != 0 || bus.rsp_valid) && n < 50) begin
            tick();
            n++;
        end
        chk(name, sb.size(), 0);
    endtask

    task automatic chk_stats(input string tag, input int ops, input int emax, input int eacc);
        chk({tag, "_ops"}, int'(stat_ops), STATS ? ops : 0);
        chk({tag, "_err_max"}, int'(stat_err_max), STATS ? emax : 0);
        chk({tag, "_err_acc"}, int'(stat_err_acc), STATS ? eacc : 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        set_req(0, 8'h10, 8'h20, 9'h038);
        set_req(1, 8'hFF, 8'hFF, 9'h1FE);
        set_req(2, 8'h0F, 8'h01, 9'h008);
        set_req(3, 8'hA8, 8'h5C, 9'h10F);
        bus.req_valid = '1;
        bus.rsp_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_req_ready", int'(bus.req_ready), 0);
        chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
        chk("rst_rsp_id", int'(bus.rsp_id), 0);
        chk("rst_rsp_sum", int'(bus.rsp_sum), 0);
        chk_stats("rst", 0, 0, 0);

        // Round robin from reset: 0,1,2,3,0 every second cycle.
        for (int k = 0; k < 5; k++) grant_q.push_back(k % 4);
        rst_n = 1'b1;
        wait_accepts(5, "rr_accepts");
        tick();
        bus.req_valid = '0;
        for (int k = 1; k < acc_cycles.size(); k++)
            chk("rr_spacing", acc_cycles[k] - acc_cycles[k-1], 2);
        wait_drain("rr_drain");
        chk_stats("rr", 5, 11, 35);

        // Single op on requester 2.
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        chk_stats("clr1", 0, 0, 0);
        set_req(2, 8'h10, 8'h20, 9'h038);
        grant_q.push_back(2);
        bus.req_valid[2] = 1'b1;
        wait_accepts(6, "single_accept");
        tick();
        bus.req_valid[2] = 1'b0;
        wait_drain("single_drain");
        chk_stats("single", 1, 8, 8);

        // Backpressure: hold five cycles, then accept in the release cycle.
        bus.rsp_ready = 1'b0;
        set_req(1, 8'hA8, 8'h5C, 9'h10F);
        grant_q.push_back(1);
        bus.req_valid[1] = 1'b1;
        wait_accepts(7, "bp_accept1");
        tick();
        bus.req_valid[1] = 1'b0;
        set_req(3, 8'h33, 8'hC4, 9'h0FF);
        grant_q.push_back(3);
        bus.req_valid[3] = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #2;
            chk("bp_rsp_valid", int'(bus.rsp_valid), 1);
            chk("bp_rsp_id", int'(bus.rsp_id), 1);
            chk("bp_rsp_sum", int'(bus.rsp_sum), 'h10F);
            chk("bp_no_ready", int'(bus.req_ready), 0);
            chk("bp_no_accept", accepts, 7);
            tick();
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        #2;
        chk("bp_release_accept", accepts, 8);
        if (acc_cycles.size() > 0) chk("bp_release_cycle", acc_cycles[acc_cycles.size()-1], cyc);
        tick();
        bus.req_valid[3] = 1'b0;
        wait_drain("bp_drain");

        // Reset during CALC discards the operation and the pointer.
        set_req(0, 8'hFF, 8'hFF, 9'h1FE);
        grant_q.push_back(0);
        bus.req_valid[0] = 1'b1;
        wait_accepts(9, "mr_accept");
        tick();
        rst_n = 1'b0;
        bus.req_valid[0] = 1'b0;
        if (sb.size() > 0) void'(sb.pop_back());
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #2;
            chk("mr_rsp_valid_in_rst", int'(bus.rsp_valid), 0);
        end
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #2;
            chk("mr_rsp_valid_after", int'(bus.rsp_valid), 0);
        end
        chk_stats("mr", 0, 0, 0);

        // Pointer back at 0 after reset; also the stats sequence.
        tick();
        set_req(1, 8'h0F, 8'h01, 9'h008);
        grant_q.push_back(0);
        grant_q.push_back(1);
        bus.req_valid = 4'b0011;
        wait_accepts(10, "post_rst_accept0");
        tick();
        bus.req_valid[0] = 1'b0;
        wait_accepts(11, "post_rst_accept1");
        tick();
        bus.req_valid[1] = 1'b0;
        wait_drain("post_rst_drain");
        chk_stats("stats", 2, 8, 8);

        // stat_clr in the handshake cycle wins; that handshake is not counted.
        set_req(2, 8'h10, 8'h20, 9'h038);
        grant_q.push_back(2);
        bus.req_valid[2] = 1'b1;
        wait_accepts(12, "clr_accept");
        tick();
        bus.req_valid[2] = 1'b0;
        tick();
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        wait_drain("clr_drain");
        chk_stats("clr_hs", 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/add8u_arb4.md
# add8u_arb4

Shared-adder scheduler for the approximate 8-bit unsigned adder datapath. Up to NREQ requesters present operand pairs over valid/ready. A round-robin arbiter grants one requester at a time to a single approximate add8u instance, and the 9-bit result returns tagged with the requester ID over a registered valid/ready response port. An optional monitor compares each result against the exact sum and accumulates error statistics.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- IDW, $clog2(NREQ), requester ID width
- ACC_W, 20, width of the saturating error accumulator

Ports:
- clk  in  1  clock, all state rising-edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  request valid, bit i = requester i
- req_ready  out  NREQ  request accepted, at most one bit high
- req_a  in  8*NREQ  operand A, requester i in bits [8i+7:8i]
- req_b  in  8*NREQ  operand B, same packing
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  IDW  requester ID of the response
- rsp_sum  out  9  approximate sum
- stat_clr  in  1  synchronous clear of statistics
- stat_ops  out  16  completed responses, saturating
- stat_err_max  out  4  maximum |exact − approx| seen
- stat_err_acc  out  ACC_W  sum of |exact − approx|, saturating

## Operation
- Approximate sum s of a, b:
  - s[8:4] = a[7:4] + b[7:4] + (a[3] & b[3]), 5-bit result.
  - s[3] = 1.
  - s[2] = b[2].
  - s[1] = a[5].
  - s[0] = a[7] ^ b[7].
  - The worst-case error is 11.
- FSM states:
  - IDLE: no operation in flight.
  - CALC: the operand latch is loaded, and the result register loads at the end of the cycle.
  - HOLD: rsp_valid = 1.
- Transitions:
  - IDLE → CALC on any req_valid.
  - CALC → HOLD always.
  - HOLD → IDLE on rsp_ready with no req_valid.
  - HOLD → CALC on rsp_ready with some req_valid. The new request is accepted in the same cycle.
  - HOLD stays HOLD while !rsp_ready.
- Accept window:
  - req_ready[g] is high only in IDLE, or in HOLD & rsp_ready, for the winner g.
  - req_ready is combinational from req_valid, the state and the pointer.
  - Transfer occurs when req_valid[g] & req_ready[g].
- Arbitration:
  - The pointer p selects the first valid index searching p, p+1, … NREQ−1, 0, … with wrap.
  - After a grant to g, p = (g+1) mod NREQ.
  - p is unchanged when nothing is granted.
- Response hold:
  - rsp_id, rsp_sum and rsp_valid hold stable in HOLD until rsp_ready.
  - Requesters may drop or change req_valid/req_a/req_b at any time before the transfer. Only the values at transfer are used.
- Reset values:
  - State IDLE, p = 0.
  - req_ready = 0, rsp_valid = 0, rsp_id = 0, rsp_sum = 0.
  - All stat outputs 0.
- Asserting rst_n low mid-operation discards the in-flight operation immediately. No response is produced.

## Timing
- Latency: a request transfer in cycle n gives rsp_valid high from cycle n+2.
- Peak throughput: one result per 2 cycles with rsp_ready held high.
- Backpressure adds one cycle per cycle of rsp_ready low. No requests are accepted during that time.
- Stats update on the response handshake (rsp_valid & rsp_ready) cycle, visible the next cycle.
- stat_clr takes priority over a same-cycle update. The result is all zeros, and that handshake is not counted.

## Configuration
- ADD8U_ARB_STATS_EN defined:
  - The exact 9-bit sum a + b is computed alongside the approximate sum and registered with the result.
  - On each response handshake, stat_ops increments (saturating at 0xFFFF).
  - stat_err_max becomes max(stat_err_max, |err|).
  - stat_err_acc adds |err|, saturating at all-ones.
- ADD8U_ARB_STATS_EN undefined:
  - The monitor logic is absent.
  - stat_ops, stat_err_max and stat_err_acc are tied to 0, and stat_clr is ignored.
  - Arbitration and response behaviour are identical.

## Test plan
- Reset: hold rst_n = 0 with all req_valid = 1 → req_ready = 0, rsp_valid = 0, all stats 0. After release, the first grant goes to requester 0.
- Single op: requester 2 sends a = 0x10, b = 0x20 at cycle n → rsp_valid at n+2 with rsp_id = 2 and rsp_sum = 0x038. The exact sum is 0x030; with stats enabled, stat_err_max = 8.
- Round-robin: all 4 requesters valid continuously, rsp_ready = 1 → grants 0, 1, 2, 3, 0 on every second cycle. Exactly one req_ready bit is high per accept.
- Backpressure: rsp_ready = 0 for 5 cycles while in HOLD → rsp_id/rsp_sum stable, no req_ready. On rsp_ready = 1, the next request is accepted in the same cycle.
- Stats: a = b = 0xFF then a = 0x0F, b = 0x01 → sums 0x1FE (err 0) and 0x008 (err 8). Expected stat_ops = 2, stat_err_max = 8, stat_err_acc = 8. stat_clr then zeros all three.
- Reset mid-op: assert rst_n low during CALC → rsp_valid stays 0. After release the state is IDLE and the pointer 0. No stale response appears.
